// File: rtl/dmem_wait_responder.sv
// Data-memory responder: word loads/stores from an internal RAM after WAIT_CYCLES wait states,
// with misalignment and range faults reported alongside the one-cycle ready pulse.
module dmem_wait_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        stall,
  output logic [1:0]  dbg_state
);

  // Handshake: the core raises req with we/addr/wdata and holds it until ready; ready is a
  // one-cycle pulse, and req still high in the following (IDLE) cycle starts a new access.

  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic           l_we;
  logic           l_fault;
  logic [AW-1:0]  l_idx;
  logic [31:0]    l_wdata;

  logic [31:0]    mem [DEPTH_WORDS];

  logic [31:0]    in_off;
  logic           in_fault;
  logic [AW-1:0]  in_idx;

  logic           go_resp;
  logic           r_we;
  logic           r_fault;
  logic [AW-1:0]  r_idx;
  logic [31:0]    r_wdata;
  logic           wr_en;

  // Unsigned 32-bit compares: an address below the base never wraps into range.
  always_comb begin
    in_off   = addr - BASE_ADDR;
    in_idx   = in_off[AW+1:2];
    in_fault = (addr[1:0] != 2'b00) || (addr < BASE_ADDR) ||
               ((in_off >> 2) >= 32'(DEPTH_WORDS));
  end

  // Select the access being completed on this edge: the latched one, or the incoming one
  // when there are no wait states and IDLE goes straight to RESP.
  always_comb begin
    go_resp = 1'b0;
    r_we    = l_we;
    r_fault = l_fault;
    r_idx   = l_idx;
    r_wdata = l_wdata;
    case (state)
      IDLE: begin
        if (req && ZERO_WAIT) begin
          go_resp = 1'b1;
          r_we    = we;
          r_fault = in_fault;
          r_idx   = in_idx;
          r_wdata = wdata;
        end
      end
      WAIT: go_resp = (cnt == 4'd0);
      default: go_resp = 1'b0;
    endcase
  end

  assign wr_en = go_resp && r_we && !r_fault && !reset;

  always_ff @(posedge clk) begin
    if (wr_en) mem[r_idx] <= r_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ready   <= 1'b0;
      rdata   <= 32'h0;
      err     <= 1'b0;
      l_we    <= 1'b0;
      l_fault <= 1'b0;
      l_idx   <= '0;
      l_wdata <= 32'h0;
    end else begin
      ready <= 1'b0;
      rdata <= 32'h0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            l_we    <= we;
            l_fault <= in_fault;
            l_idx   <= in_idx;
            l_wdata <= wdata;
            if (ZERO_WAIT) begin
              state <= RESP;
            end else begin
              cnt   <= 4'(WAIT_CYCLES - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else cnt <= cnt - 4'd1;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
      // Loads see the word as it was before this edge; stores and faults return zero.
      if (go_resp) begin
        ready <= 1'b1;
        err   <= r_fault;
        rdata <= (r_fault || r_we) ? 32'h0 : mem[r_idx];
      end
    end
  end

  assign stall     = req & ~ready;
  assign dbg_state = state;

endmodule
